// File: rtl/vram_arbiter.sv
// Two-requester VRAM arbiter: display scanout has priority over the CPU, with an optional
// anti-starvation burst limit enabled by defining VRAM_ARB_FAIRNESS_EN.
module vram_arbiter #(
   parameter int unsigned AW        = 16,
   parameter int unsigned DW        = 16,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic          clk_main,
   input  logic          rst,
   input  logic          disp_req,
   input  logic [AW-1:0] disp_addr,
   output logic          disp_gnt,
   output logic          disp_rvalid,
   output logic [DW-1:0] disp_rdata,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_gnt,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DISP,
      ST_CPU
   } state_t;

   state_t state, state_nxt;
   logic   fair_fire;

`ifdef VRAM_ARB_FAIRNESS_EN
   logic [7:0] burst_cnt;

   assign fair_fire = cpu_req && (burst_cnt == 8'(MAX_BURST));

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
      end else if (!cpu_req || cpu_gnt) begin
         burst_cnt <= '0;
      end else if (disp_gnt && (burst_cnt < 8'(MAX_BURST))) begin
         burst_cnt <= burst_cnt + 8'd1;
      end
   end
`else
   assign fair_fire = 1'b0;
`endif

   // Grants are forced low while rst is held so nothing is accepted during reset.
   always_comb begin
      disp_gnt  = 1'b0;
      cpu_gnt   = 1'b0;
      state_nxt = ST_IDLE;
      if (!rst) begin
         if (disp_req && !fair_fire) begin
            disp_gnt  = 1'b1;
            state_nxt = ST_DISP;
         end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            state_nxt = ST_CPU;
         end
      end
   end

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en <= disp_gnt || cpu_gnt;
         mem_we <= cpu_gnt && cpu_we;
         if (disp_gnt) begin
            mem_addr <= disp_addr;
         end else if (cpu_gnt) begin
            mem_addr <= cpu_addr;
            if (cpu_we) begin
               mem_wdata <= cpu_wdata;
            end
         end
      end
   end

   // Tag stage 0 is the issue cycle itself: state still names the requester granted last
   // cycle, which is exactly the one whose command is on mem_* now.
   logic              issue_rd;
   logic              issue_cpu;
   logic [RD_LAT-1:0] tag_vld;
   logic [RD_LAT-1:0] tag_cpu;

   assign issue_rd  = mem_en && !mem_we;
   assign issue_cpu = (state == ST_CPU);

   always_ff @(posedge clk_main or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         tag_cpu <= '0;
      end else begin
         tag_vld <= RD_LAT'({tag_vld, issue_rd});
         tag_cpu <= RD_LAT'({tag_cpu, issue_cpu});
      end
   end

   assign disp_rvalid = tag_vld[RD_LAT-1] && !tag_cpu[RD_LAT-1];
   assign cpu_rvalid  = tag_vld[RD_LAT-1] &&  tag_cpu[RD_LAT-1];
   assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
   assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios plus random traffic against a
// behavioural model (grant rule, response queue, model memory).
module tb_vram_arbiter;
   localparam int unsigned AW        = 16;
   localparam int unsigned DW        = 16;
   localparam int unsigned RD_LAT    = 2;
   localparam int unsigned MAX_BURST = 8;

   logic          clk_main = 1'b0;
   logic          rst;
   logic          disp_req, disp_gnt, disp_rvalid;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_rdata;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   vram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)) dut (
      .clk_main(clk_main), .rst(rst),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
      .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk_main = ~clk_main;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] default_word(input int unsigned a);
      return DW'(a) ^ DW'(16'hA5C3);
   endfunction

   // Memory device: samples the command ending each cycle, returns read data RD_LAT cycles on.
   logic [DW-1:0] env_mem [0:(1<<AW)-1];
   logic [DW-1:0] rd_pipe [RD_LAT];
   assign mem_rdata = rd_pipe[RD_LAT-1];

   initial begin
      for (int i = 0; i < (1<<AW); i++) env_mem[i] = default_word(i);
      env_mem[16'h0010] = 16'hBEEF;
      for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;
      forever begin
         @(posedge clk_main);
         if (mem_en && mem_we) env_mem[mem_addr] = mem_wdata;
         for (int i = int'(RD_LAT) - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
         rd_pipe[0] = (mem_en && !mem_we) ? env_mem[mem_addr] : DW'($urandom);
      end
   end

   // Reference model
   typedef struct {
      int            due;
      logic          cpu;
      logic [DW-1:0] data;
   } resp_t;

   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   int n_rd_d = 0, n_rv_d = 0, n_rd_c = 0, n_rv_c = 0;

   initial begin
      resp_t         q[$];
      resp_t         r;
      int            cyc = 0;
      int            run = 0;
      logic          pend_en = 1'b0, pend_we = 1'b0;
      logic [AW-1:0] pend_addr = '0;
      logic [DW-1:0] pend_wdata = '0;
      logic          fire, e_dg, e_cg, e_dv, e_cv;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] = default_word(i);
      ref_mem[16'h0010] = 16'hBEEF;
      forever begin
         @(negedge clk_main);
         cyc++;
         if (rst) begin
            chk("rst_gnt", {disp_gnt, cpu_gnt}, 0);
            chk("rst_rvalid", {disp_rvalid, cpu_rvalid}, 0);
            chk("rst_mem_strobe", {mem_en, mem_we}, 0);
            chk("rst_mem_bus", {mem_addr, mem_wdata}, 0);
            chk("rst_rdata", {disp_rdata, cpu_rdata}, 0);
            q.delete();
            run = 0;
            pend_en = 1'b0;
            pend_we = 1'b0;
            n_rd_d = 0; n_rv_d = 0; n_rd_c = 0; n_rv_c = 0;
         end else begin
`ifdef VRAM_ARB_FAIRNESS_EN
            fire = cpu_req && (run >= int'(MAX_BURST));
`else
            fire = 1'b0;
`endif
            e_dg = disp_req && !fire;
            e_cg = cpu_req && !e_dg;
            chk("disp_gnt", disp_gnt, e_dg);
            chk("cpu_gnt", cpu_gnt, e_cg);
            chk("gnt_exclusive", disp_gnt && cpu_gnt, 0);
            chk("mem_en", mem_en, pend_en);
            chk("mem_we", mem_we, pend_we);
            if (pend_en) chk("mem_addr", mem_addr, pend_addr);
            if (pend_en && pend_we) chk("mem_wdata", mem_wdata, pend_wdata);

            e_dv = 1'b0;
            e_cv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
               r = q.pop_front();
               if (r.cpu) e_cv = 1'b1; else e_dv = 1'b1;
            end
            chk("disp_rvalid", disp_rvalid, e_dv);
            chk("cpu_rvalid", cpu_rvalid, e_cv);
            if (e_dv) chk("disp_rdata", disp_rdata, r.data);
            if (e_cv) chk("cpu_rdata", cpu_rdata, r.data);

            // Consecutive display wins while the CPU keeps waiting.
            if (!cpu_req || e_cg) run = 0;
            else if (e_dg) run++;
            pend_en    = e_dg || e_cg;
            pend_we    = e_cg && cpu_we;
            pend_addr  = e_dg ? disp_addr : cpu_addr;
            pend_wdata = cpu_wdata;
            if (e_dg) q.push_back('{due: cyc + 1 + int'(RD_LAT), cpu: 1'b0, data: ref_mem[disp_addr]});
            if (e_cg && !cpu_we) q.push_back('{due: cyc + 1 + int'(RD_LAT), cpu: 1'b1, data: ref_mem[cpu_addr]});
            if (e_cg && cpu_we) ref_mem[cpu_addr] = cpu_wdata;

            n_rd_d += int'(disp_gnt);
            n_rd_c += int'(cpu_gnt && !cpu_we);
            n_rv_d += int'(disp_rvalid);
            n_rv_c += int'(cpu_rvalid);
         end
      end
   end

   task automatic step();
      @(posedge clk_main);
      #1;
   endtask

   task automatic smp();
      @(negedge clk_main);
   endtask

   initial begin
      int   nd, nc, pd, pc;
      logic gd, gc;
      rst = 1'b1;
      disp_req = 1'b1; disp_addr = '0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      smp();
      smp();
      chk("reset_disp_gnt", disp_gnt, 0);
      chk("reset_cpu_gnt", cpu_gnt, 0);
      chk("reset_mem_en", mem_en, 0);
      chk("reset_disp_rvalid", disp_rvalid, 0);

      // Display request still held at release: granted in the very first cycle.
      step(); rst = 1'b0; cpu_req = 1'b0;
      smp(); chk("first_cycle_gnt", disp_gnt, 1);
      step(); disp_req = 1'b0;
      repeat (5) step();

      // Single CPU read of 0x0010.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
      smp(); chk("rd_cpu_gnt", cpu_gnt, 1);
      step(); cpu_req = 1'b0;
      smp();
      chk("rd_mem_en", mem_en, 1);
      chk("rd_mem_we", mem_we, 0);
      chk("rd_mem_addr", mem_addr, 16'h0010);
      step(); smp(); chk("rd_early_rvalid", cpu_rvalid, 0);
      step(); smp();
      chk("rd_cpu_rvalid", cpu_rvalid, 1);
      chk("rd_cpu_rdata", cpu_rdata, 16'hBEEF);
      chk("rd_no_disp_rvalid", disp_rvalid, 0);

      // CPU write of 0x1234 to 0x0042.
      step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'h1234;
      smp(); chk("wr_cpu_gnt", cpu_gnt, 1);
      step(); cpu_req = 1'b0; cpu_we = 1'b0;
      smp();
      chk("wr_mem_en", mem_en, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 16'h0042);
      chk("wr_mem_wdata", mem_wdata, 16'h1234);
      repeat (4) begin step(); smp(); chk("wr_no_cpu_rvalid", cpu_rvalid, 0); end

      // Interleaved display / CPU / display reads on consecutive cycles.
      step(); disp_req = 1'b1; disp_addr = 16'h0100;
      smp(); chk("il_gnt0", disp_gnt, 1);
      step(); disp_req = 1'b0; cpu_req = 1'b1; cpu_addr = 16'h0200;
      smp(); chk("il_gnt1", cpu_gnt, 1);
      step(); cpu_req = 1'b0; disp_req = 1'b1; disp_addr = 16'h0101;
      smp(); chk("il_gnt2", disp_gnt, 1);
      step(); disp_req = 1'b0;
      smp();
      chk("il_rv0", {disp_rvalid, cpu_rvalid}, 2'b10);
      chk("il_data0", disp_rdata, 16'hA4C3);
      step(); smp();
      chk("il_rv1", {disp_rvalid, cpu_rvalid}, 2'b01);
      chk("il_data1", cpu_rdata, 16'hA7C3);
      step(); smp();
      chk("il_rv2", {disp_rvalid, cpu_rvalid}, 2'b10);
      chk("il_data2", disp_rdata, 16'hA4C2);

      // Both requesters held for 20 cycles.
      step(); disp_req = 1'b1; disp_addr = 16'h0300; cpu_req = 1'b1; cpu_addr = 16'h0301;
      nd = 0; nc = 0;
      for (int i = 0; i < 20; i++) begin
         smp();
         nd += int'(disp_gnt);
         nc += int'(cpu_gnt);
         step();
      end
`ifdef VRAM_ARB_FAIRNESS_EN
      chk("burst_disp_count", nd, 18);
      chk("burst_cpu_count", nc, 2);
`else
      chk("burst_disp_count", nd, 20);
      chk("burst_cpu_count", nc, 0);
`endif
      disp_req = 1'b0;
      smp(); step(); cpu_req = 1'b0;
      repeat (6) begin smp(); step(); end

      // Reset one cycle after a display read grant.
      disp_req = 1'b1; disp_addr = 16'h0400;
      smp(); chk("rst_mid_gnt", disp_gnt, 1);
      step(); disp_req = 1'b0; rst = 1'b1;
      #1;
      chk("rst_mid_strobe", {mem_en, mem_we, disp_gnt, cpu_gnt}, 0);
      chk("rst_mid_bus", {mem_addr, mem_wdata}, 0);
      chk("rst_mid_resp", {disp_rvalid, cpu_rvalid, disp_rdata, cpu_rdata}, 0);
      smp(); step(); rst = 1'b0;
      repeat (6) begin smp(); chk("rst_mid_no_rvalid", disp_rvalid, 0); step(); end

      // Random traffic, alternating light and heavy load phases.
      for (int n = 0; n < 3000; n++) begin
         smp();
         gd = disp_gnt;
         gc = cpu_gnt;
         step();
         pd = ((n / 500) % 2 == 1) ? 90 : 40;
         pc = ((n / 500) % 2 == 1) ? 90 : 30;
         if (!disp_req || gd) begin
            disp_req  = ($urandom_range(99) < pd);
            disp_addr = AW'($urandom_range(16'h10FF, 16'h1000));
         end
         if (!cpu_req || gc) begin
            cpu_req   = ($urandom_range(99) < pc);
            cpu_we    = 1'($urandom_range(1));
            cpu_addr  = AW'($urandom_range(16'h103F, 16'h1000));
            cpu_wdata = DW'($urandom);
         end
      end
      disp_req = 1'b0;
      repeat (300) begin
         smp(); gc = cpu_gnt; step();
         if (gc) cpu_req = 1'b0;
         if (!cpu_req) break;
      end
      cpu_req = 1'b0;
      repeat (8) begin smp(); step(); end
      chk("disp_rvalid_count", n_rv_d, n_rd_d);
      chk("cpu_rvalid_count", n_rv_c, n_rd_c);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 16, memory word-address width.
REQ-002 Parameter DW, default 16, data width.
REQ-003 Parameter RD_LAT, default 2, memory read latency in cycles, range 1..4.
REQ-004 Parameter MAX_BURST, default 8, consecutive display grants allowed while CPU waits, range 1..255.
REQ-005 clk_main  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 disp_req  in  1  scanout fetch request, held until granted.
REQ-008 disp_addr  in  AW  scanout read address.
REQ-009 disp_gnt  out  1  scanout request accepted this cycle.
REQ-010 disp_rvalid  out  1  disp_rdata valid.
REQ-011 disp_rdata  out  DW  scanout read data.
REQ-012 cpu_req  in  1  CPU request, held with stable fields until granted.
REQ-013 cpu_we  in  1  1 = write, 0 = read.
REQ-014 cpu_addr  in  AW  CPU address.
REQ-015 cpu_wdata  in  DW  CPU write data.
REQ-016 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-017 cpu_rvalid  out  1  cpu_rdata valid.
REQ-018 cpu_rdata  out  DW  CPU read data.
REQ-019 mem_en, mem_we  out  1 each  registered memory strobe and write enable.
REQ-020 mem_addr  out  AW; mem_wdata  out  DW; registered.
REQ-021 mem_rdata  in  DW  valid RD_LAT cycles after a mem_en cycle with mem_we=0.

Function
REQ-022 One grant at most per cycle; disp_gnt and cpu_gnt SHALL never both be 1.
REQ-023 Grants combinational from current state and requests; accepted request drives mem_* on the following cycle (1-cycle issue latency).
REQ-024 Priority: display wins unless the fairness guard fires (REQ-031); CPU granted otherwise when cpu_req=1.
REQ-025 FSM states IDLE (no grant last cycle), DISP (display granted last cycle), CPU (CPU granted last cycle); next state follows the grant issued this cycle.
REQ-026 burst_cnt (8 bits): increments on each display grant while cpu_req=1, saturates at MAX_BURST; clears on CPU grant or any cycle with cpu_req=0.
REQ-027 Read tag pipeline of depth 1+RD_LAT records requester of each issued read; rvalid pulses for exactly one cycle, 1+RD_LAT cycles after the grant cycle, to the tagged requester only.
REQ-028 rdata outputs carry mem_rdata in the rvalid cycle; value undefined otherwise.
REQ-029 CPU writes produce no cpu_rvalid; display never writes.
REQ-030 Back-to-back grants every cycle SHALL be sustained; responses return in grant order.

Reset
REQ-031a While rst=1: state IDLE, burst_cnt=0, tag pipeline cleared, all gnt/rvalid/mem_en/mem_we=0, mem_addr/mem_wdata/rdata=0.
REQ-032 Reset mid-operation discards in-flight reads; no rvalid SHALL follow for them after rst deasserts.
REQ-033 First grant possible in the first cycle after rst deasserts.

Configuration
REQ-031 Macro VRAM_ARB_FAIRNESS_EN defined: when cpu_req=1 and burst_cnt=MAX_BURST, CPU is granted over a pending display request. Undefined: display has strict priority, burst_cnt is not implemented, CPU may starve.

Verification
REQ-034 Single CPU read addr 0x0010, memory returns 0xBEEF, RD_LAT=2 -> cpu_gnt at cycle t, mem_en at t+1, cpu_rvalid with 0xBEEF at t+3, disp_rvalid stays 0.
REQ-035 disp_req and cpu_req both held 20 cycles, fairness on, MAX_BURST=8 -> 8 display grants, 1 CPU grant, repeating; fairness off -> 20 display grants, 0 CPU grants.
REQ-036 Interleaved reads display 0x0100, CPU 0x0200, display 0x0101 on consecutive cycles -> rvalids in same order to correct requester, no cycle gaps.
REQ-037 CPU write addr 0x0042 data 0x1234 -> mem_en=1, mem_we=1, mem_addr=0x0042, mem_wdata=0x1234 one cycle after cpu_gnt; no cpu_rvalid.
REQ-038 rst asserted one cycle after a display read grant -> all outputs 0 immediately; no disp_rvalid after release.
REQ-039 Continuous assertion checks: never both grants; rvalid count equals read-grant count per requester outside reset.
